// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller and the write-back mux.
package ctrl_pkg;

    localparam int OP_W = 4;
    localparam int WB_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    localparam logic [OP_W-1:0] OP_RALU  = 4'h0;
    localparam logic [OP_W-1:0] OP_IALU  = 4'h1;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h2;
    localparam logic [OP_W-1:0] OP_STORE = 4'h3;
    localparam logic [OP_W-1:0] OP_LUI   = 4'h4;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'h5;
    localparam logic [OP_W-1:0] OP_JAL   = 4'h6;
    localparam logic [OP_W-1:0] OP_IN    = 4'h7;
    localparam logic [OP_W-1:0] OP_HALT  = 4'hF;

    localparam logic [WB_W-1:0] WB_ALU   = 3'd0;
    localparam logic [WB_W-1:0] WB_MEM   = 3'd1;
    localparam logic [WB_W-1:0] WB_IMM   = 3'd2;
    localparam logic [WB_W-1:0] WB_LINK  = 3'd3;
    localparam logic [WB_W-1:0] WB_UPPER = 3'd4;
    localparam logic [WB_W-1:0] WB_IN    = 3'd5;

    function automatic logic is_legal(input logic [OP_W-1:0] op);
        return (op <= OP_IN) || (op == OP_HALT);
    endfunction

    function automatic logic [WB_W-1:0] wb_sel_of(input logic [OP_W-1:0] op);
        logic [WB_W-1:0] sel;
        case (op)
            OP_LOAD: sel = WB_MEM;
            OP_LUI:  sel = WB_UPPER;
            OP_JAL:  sel = WB_LINK;
            OP_IN:   sel = WB_IN;
            default: sel = WB_ALU;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Output decode of the controller: state plus latched opcode to enables and write-back select.
module ctrl_out_decode
    import ctrl_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] opc_q_i,
    input  logic [OP_W-1:0] opc_in_i,
    input  logic            zero_i,
    input  logic            mem_rdy_i,
    output logic            pc_write_o,
    output logic            ir_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            reg_write_o,
    output logic [WB_W-1:0] wb_sel_o,
    output logic            pc_src_o,
    output logic            illegal_o,
    output logic            halted_o
);

    // Moore decode; only the FETCH/MEM register loads look at the memory handshake.
    always_comb begin
        pc_write_o  = 1'b0;
        ir_write_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        reg_write_o = 1'b0;
        pc_src_o    = 1'b0;
        illegal_o   = 1'b0;
        halted_o    = 1'b0;
        // select follows the last decoded opcode so the mux settles before REG_WRITE
        if (state_i == IDLE) begin
            wb_sel_o = WB_ALU;
        end else begin
            wb_sel_o = wb_sel_of(opc_q_i);
        end
        case (state_i)
            FETCH: begin
                mem_read_o = 1'b1;
                ir_write_o = mem_rdy_i;
                pc_write_o = mem_rdy_i;
            end
            DECODE: begin
                illegal_o = ~is_legal(opc_in_i);
            end
            EXEC: begin
                if (opc_q_i == OP_BEQ) begin
                    pc_write_o = zero_i;
                    pc_src_o   = 1'b1;
                end else begin
                    pc_src_o   = 1'b0;
                end
            end
            MEM: begin
                if (opc_q_i == OP_LOAD) begin
                    mem_read_o  = 1'b1;
                end else if (opc_q_i == OP_STORE) begin
                    mem_write_o = 1'b1;
                end else begin
                    mem_read_o  = 1'b0;
                end
            end
            WB: begin
                reg_write_o = 1'b1;
                if (opc_q_i == OP_JAL) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                end else begin
                    pc_src_o   = 1'b0;
                end
            end
            HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                halted_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/write-back controller with a retired-instruction counter.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int SELW = 3,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [OPW-1:0]  OPCODE,
    input  logic            ZERO,
    input  logic            MEM_RDY,
    output logic            PC_WRITE,
    output logic            IR_WRITE,
    output logic            MEM_READ,
    output logic            MEM_WRITE,
    output logic            REG_WRITE,
    output logic [SELW-1:0] WB_SEL,
    output logic            PC_SRC,
    output logic            ILLEGAL,
    output logic            HALTED,
    output logic [CNTW-1:0] RETIRED
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   opc_q, opc_d;
    logic [CNTW-1:0]   retired_q, retired_d;
    logic [OP_W-1:0]   opc_in_s;
    logic [WB_W-1:0]   wb_sel_s;
    logic              retire_s;

    assign opc_in_s = OP_W'(OPCODE);

    // State, latched opcode and retire counter; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            opc_q     <= {OP_W{1'b0}};
            retired_q <= {CNTW{1'b0}};
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            retired_q <= retired_d;
        end
    end

    // Next-state sequencing and retire detection.
    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        retire_s = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (MEM_RDY) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                opc_d = opc_in_s;
                if (opc_in_s == OP_HALT) begin
                    state_d  = HALT;
                    retire_s = 1'b1;
                end else if (!is_legal(opc_in_s)) begin
                    state_d  = FETCH;
                end else begin
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (opc_q == OP_BEQ) begin
                    state_d  = FETCH;
                    retire_s = 1'b1;
                end else if ((opc_q == OP_LOAD) || (opc_q == OP_STORE)) begin
                    state_d  = MEM;
                end else begin
                    state_d  = WB;
                end
            end
            MEM: begin
                if (!MEM_RDY) begin
                    state_d  = MEM;
                end else if (opc_q == OP_LOAD) begin
                    state_d  = WB;
                end else begin
                    state_d  = FETCH;
                    retire_s = 1'b1;
                end
            end
            WB: begin
                state_d  = FETCH;
                retire_s = 1'b1;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (retire_s) begin
            retired_d = retired_q + CNTW'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    ctrl_out_decode u_out_decode (
        .state_i     (state_q),
        .opc_q_i     (opc_q),
        .opc_in_i    (opc_in_s),
        .zero_i      (ZERO),
        .mem_rdy_i   (MEM_RDY),
        .pc_write_o  (PC_WRITE),
        .ir_write_o  (IR_WRITE),
        .mem_read_o  (MEM_READ),
        .mem_write_o (MEM_WRITE),
        .reg_write_o (REG_WRITE),
        .wb_sel_o    (wb_sel_s),
        .pc_src_o    (PC_SRC),
        .illegal_o   (ILLEGAL),
        .halted_o    (HALTED)
    );

    assign WB_SEL  = SELW'(wb_sel_s);
    assign RETIRED = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: instruction-level reference model, directed table, random instruction stream.
module tb_multicycle_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [3:0]  OPCODE = 4'h0;
    logic        ZERO = 1'b0;
    logic        MEM_RDY = 1'b0;
    logic        PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, PC_SRC, ILLEGAL, HALTED;
    logic [2:0]  WB_SEL;
    logic [15:0] RETIRED;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] ret_m = 16'd0;
    int          n_rw;
    logic [2:0]  seen_sel;

    multicycle_ctrl_fsm #(.OPW(4), .SELW(3), .CNTW(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
        .PC_WRITE(PC_WRITE), .IR_WRITE(IR_WRITE), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .REG_WRITE(REG_WRITE), .WB_SEL(WB_SEL), .PC_SRC(PC_SRC), .ILLEGAL(ILLEGAL),
        .HALTED(HALTED), .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    // Output vector layout: pcw irw mr mw rw sel[2:0] src ill hlt
    function automatic logic [10:0] act();
        return {PC_WRITE, IR_WRITE, MEM_READ, MEM_WRITE, REG_WRITE, WB_SEL, PC_SRC, ILLEGAL, HALTED};
    endfunction

    function automatic logic [10:0] e(input logic pcw, input logic irw, input logic mr, input logic mw,
                                      input logic rw, input logic [2:0] sel, input logic src,
                                      input logic ill, input logic hlt);
        return {pcw, irw, mr, mw, rw, sel, src, ill, hlt};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, x, $time);
        end
    endtask

    // One clock: drive, compare at the falling edge, advance; model counter bumps on retire.
    task automatic cyc(input logic rdy, input logic z, input logic [10:0] x, input logic ret, input string nm);
        logic [10:0] m;
        MEM_RDY = rdy;
        ZERO    = z;
        @(negedge CLK);
        m = x[6] ? 11'h7FF : 11'b111_1100_0111;
        check(nm, 32'(act() & m), 32'(x & m));
        check({nm, "_retired"}, 32'(RETIRED), 32'(ret_m));
        if (REG_WRITE) begin
            n_rw++;
            seen_sel = WB_SEL;
        end
        @(posedge CLK);
        #1;
        if (ret) ret_m = ret_m + 16'd1;
    endtask

    // Expected behaviour of one instruction, starting in FETCH, derived from the phase rules.
    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        logic       legal;
        logic [2:0] sel;
        logic       ld, st, jal;
        legal = (op <= 4'd7) || (op == 4'hF);
        ld    = (op == 4'd2);
        st    = (op == 4'd3);
        jal   = (op == 4'd6);
        case (op)
            4'd2:    sel = 3'd1;
            4'd4:    sel = 3'd4;
            4'd6:    sel = 3'd3;
            4'd7:    sel = 3'd5;
            default: sel = 3'd0;
        endcase
        OPCODE = op;
        for (int i = 0; i < fw; i++) cyc(1'b0, rb(), e(0,0,1,0,0,3'd0,0,0,0), 1'b0, "fetch_wait");
        cyc(1'b1, rb(), e(1,1,1,0,0,3'd0,0,0,0), 1'b0, "fetch");
        cyc(rb(), rb(), e(0,0,0,0,0,3'd0,0,~legal,0), (op == 4'hF), "decode");
        if (op == 4'hF) begin
            for (int i = 0; i < 20; i++) cyc(rb(), rb(), e(0,0,0,0,0,3'd0,0,0,1), 1'b0, "halted");
        end else if (legal) begin
            if (op == 4'd5) begin
                cyc(rb(), z, e(z,0,0,0,0,3'd0,1,0,0), 1'b1, "exec_beq");
            end else begin
                cyc(rb(), rb(), e(0,0,0,0,0,3'd0,0,0,0), 1'b0, "exec");
                if (ld || st) begin
                    for (int i = 0; i < mw; i++) cyc(1'b0, rb(), e(0,0,ld,st,0,3'd0,0,0,0), 1'b0, "mem_wait");
                    cyc(1'b1, rb(), e(0,0,ld,st,0,3'd0,0,0,0), st, "mem");
                end
                if (!st) cyc(rb(), rb(), e(jal,0,0,0,1,sel,jal,0,0), 1'b1, "wb");
            end
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         fw;
        int         mw;
        int         d_ret;
        int         rw;
        logic [2:0] sel;
    } vec_t;

    vec_t        tbl [10];
    logic [15:0] r0;
    logic [3:0]  rop;

    initial begin
        tbl[0] = '{4'h0, 1'b0, 0, 0, 1, 1, 3'd0};
        tbl[1] = '{4'h2, 1'b0, 3, 2, 1, 1, 3'd1};
        tbl[2] = '{4'h5, 1'b1, 0, 0, 1, 0, 3'd0};
        tbl[3] = '{4'h5, 1'b0, 0, 0, 1, 0, 3'd0};
        tbl[4] = '{4'h4, 1'b0, 0, 0, 1, 1, 3'd4};
        tbl[5] = '{4'h6, 1'b0, 0, 0, 1, 1, 3'd3};
        tbl[6] = '{4'h7, 1'b0, 0, 0, 1, 1, 3'd5};
        tbl[7] = '{4'h1, 1'b0, 1, 0, 1, 1, 3'd0};
        tbl[8] = '{4'h3, 1'b0, 1, 1, 1, 0, 3'd0};
        tbl[9] = '{4'h9, 1'b0, 0, 0, 0, 0, 3'd0};

        // reset: all outputs quiet even with inputs active
        MEM_RDY = 1'b1; ZERO = 1'b1; OPCODE = 4'hF;
        #12;
        check("reset_outputs", 32'(act()), 32'd0);
        check("reset_retired", 32'(RETIRED), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("idle_outputs", 32'(act()), 32'd0);
        @(posedge CLK);
        #1;

        for (int k = 0; k < 10; k++) begin
            r0 = RETIRED;
            n_rw = 0;
            seen_sel = 3'd7;
            run_instr(tbl[k].op, tbl[k].z, tbl[k].fw, tbl[k].mw);
            check($sformatf("tbl%0d_retire_delta", k), 32'(RETIRED - r0), 32'(tbl[k].d_ret));
            check($sformatf("tbl%0d_regwrite_cycles", k), 32'(n_rw), 32'(tbl[k].rw));
            if (tbl[k].rw > 0) check($sformatf("tbl%0d_wb_sel", k), 32'(seen_sel), 32'(tbl[k].sel));
        end

        for (int k = 0; k < 60; k++) begin
            rop = 4'($urandom_range(0, 9));
            if (rop >= 4'd8) rop = 4'($urandom_range(8, 14));
            run_instr(rop, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // reset in the middle of a stalled STORE
        OPCODE = 4'h3;
        cyc(1'b1, 1'b0, e(1,1,1,0,0,3'd0,0,0,0), 1'b0, "st_fetch");
        cyc(1'b0, 1'b0, e(0,0,0,0,0,3'd0,0,0,0), 1'b0, "st_decode");
        cyc(1'b0, 1'b0, e(0,0,0,0,0,3'd0,0,0,0), 1'b0, "st_exec");
        #1;
        check("st_mem_write_before_reset", 32'(MEM_WRITE), 32'd1);
        RST_N = 1'b0;
        #1;
        check("st_mem_write_async_drop", 32'(MEM_WRITE), 32'd0);
        check("st_retired_cleared", 32'(RETIRED), 32'd0);
        ret_m = 16'd0;
        MEM_RDY = 1'b1;
        @(negedge CLK);
        check("st_reset_outputs", 32'(act()), 32'd0);
        RST_N = 1'b1;
        #1;
        check("st_idle_outputs", 32'(act()), 32'd0);
        @(posedge CLK);
        #1;

        run_instr(4'h0, 1'b0, 0, 0);
        run_instr(4'hF, 1'b0, 1, 0);
        check("final_retired", 32'(RETIRED), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control state machine for the 16-bit datapath.
- Sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives the 3-bit write-back select (S) of the downstream 6-input 16-bit write-back mux, plus all register and memory enables.
- Counts retired instructions for debug and for bench checking.

Parameters:
- OPW, 4: opcode width (IR[15:12]).
- SELW, 3: write-back select width; must match the mux select.
- CNTW, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- OPCODE  in  OPW  IR[15:12] from the instruction register; valid from DECODE onward.
- ZERO  in  1  ALU zero flag, sampled in EXEC.
- MEM_RDY  in  1  memory handshake; access completes on the cycle MEM_RDY=1.
- PC_WRITE  out  1  load PC.
- IR_WRITE  out  1  load instruction register.
- MEM_READ  out  1  memory read request.
- MEM_WRITE  out  1  memory write request.
- REG_WRITE  out  1  register file write enable.
- WB_SEL  out  SELW  write-back mux select: 0=ALU, 1=mem data, 2=sign-ext imm, 3=PC+2 (link), 4=upper imm, 5=input port.
- PC_SRC  out  1  0=PC+2, 1=branch/jump target.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- HALTED  out  1  sticky halt indicator.
- RETIRED  out  CNTW  retired-instruction count.

Behaviour:
- Reset:
  - RST_N low asynchronously forces state=IDLE, the latched opcode to 0 and RETIRED=0.
  - All outputs are 0 while in IDLE.
  - IDLE goes to FETCH on the first CLK edge after RST_N rises.
- Outputs are a Moore decode of (state, latched opcode). The exceptions are PC_WRITE and IR_WRITE in FETCH and MEM, which are additionally ANDed with MEM_RDY.
- WB_SEL holds its value in every state except IDLE, so the mux output is stable before REG_WRITE is asserted.
- Opcode map: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 LUI, 5 BEQ, 6 JAL, 7 IN, F HALT; 8-E illegal.
- FETCH:
  - MEM_READ=1.
  - Stays in FETCH while MEM_RDY=0.
  - On MEM_RDY=1: IR_WRITE=1, PC_WRITE=1 (PC_SRC=0), then go to DECODE.
- DECODE:
  - One cycle; latches OPCODE internally.
  - HALT goes to HALT.
  - Illegal opcode: ILLEGAL=1 for this cycle, then go to FETCH; RETIRED is not incremented.
  - All other opcodes go to EXEC.
- EXEC (one cycle):
  - BEQ: PC_WRITE=ZERO, PC_SRC=1, then go to FETCH (retires).
  - JAL: go to WB.
  - LOAD and STORE: go to MEM.
  - All other legal opcodes: go to WB.
- MEM:
  - LOAD asserts MEM_READ; STORE asserts MEM_WRITE.
  - Stays in MEM while MEM_RDY=0.
  - On MEM_RDY=1: LOAD goes to WB; STORE goes to FETCH (retires).
- WB:
  - REG_WRITE=1 for exactly one cycle, with WB_SEL set by opcode: R/I-ALU=0, LOAD=1, LUI=4, JAL=3, IN=5.
  - JAL additionally asserts PC_WRITE=1 with PC_SRC=1 in WB.
  - Then go to FETCH (retires).
- HALT:
  - HALTED=1 and no enables asserted.
  - Exits only on reset.
  - RETIRED increments once on entering HALT.
- RETIRED:
  - Increments by 1 on each retire event.
  - Wraps from 2^CNTW-1 to 0.
  - Never saturates.
- Latency per instruction, with memory ready immediately: BEQ 3 cycles; STORE 4; ALU/LUI/IN/JAL 4; LOAD 5. Each MEM_RDY=0 cycle adds one cycle.
- Reset during MEM or FETCH abandons the access. No enable may glitch high after RST_N falls.
- MEM_READ and MEM_WRITE are never asserted together.
- REG_WRITE and MEM_WRITE are never asserted together.

Decomposition:
- A shared ctrl_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT;
  - opcode localparams;
  - WB_SEL encodings (WB_ALU..WB_IN = 0..5), shared with the write-back mux.
- Sub-module ctrl_out_decode: combinational (state, opcode, ZERO, MEM_RDY) -> enables and WB_SEL. This keeps the FSM register block separate from the output decode.

Test Plan:
- Reset, then R-ALU with MEM_RDY=1:
  - cycle sequence FETCH, DECODE, EXEC, WB;
  - REG_WRITE high one cycle with WB_SEL=0;
  - RETIRED 0->1.
- LOAD with MEM_RDY held 0 for 3 cycles in FETCH and 2 in MEM:
  - total 10 cycles;
  - REG_WRITE with WB_SEL=1 only after the second MEM_RDY;
  - MEM_READ continuous while waiting.
- BEQ with ZERO=1, then BEQ with ZERO=0:
  - PC_WRITE=1, PC_SRC=1 in EXEC for the first only;
  - REG_WRITE never asserted;
  - RETIRED +2.
- Sweep opcodes 4, 6, 7:
  - WB_SEL=4, 3, 5 respectively at REG_WRITE;
  - JAL also shows PC_WRITE=1, PC_SRC=1 in WB.
- Opcode 9, then HALT (F):
  - ILLEGAL pulses one cycle and RETIRED is unchanged;
  - after HALT, HALTED=1 for 20 further cycles with all enables 0.
- RST_N pulled low mid-MEM of a STORE:
  - MEM_WRITE drops asynchronously and RETIRED=0;
  - after release the sequence restarts IDLE->FETCH.
- Optional wrap check with CNTW=4: 16 retires return RETIRED to 0.
